// File: rtl/fifo_pkg.sv
// Shared definitions for the sync_fifo and its stream-side read adapter:
// default widths and the output-buffer occupancy encoding.
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int CNT_WIDTH_DEF  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    // Number of words held for a given occupancy state.
    function automatic logic [2:0] occ_level(input occ_t s);
        case (s)
            ONE:     return 3'd1;
            TWO:     return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry output buffer: storage, head/tail pointers and the occupancy FSM.
// Flush empties the buffer and overrides any simultaneous push or pop.
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int data_width = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [data_width-1:0] push_data,
    input  logic                  pop,
    output occ_t                  state,
    output logic                  valid,
    output logic [data_width-1:0] head_data
);

    occ_t                  state_reg;
    occ_t                  state_next;
    logic [data_width-1:0] mem_reg [0:1];
    logic                  head_reg;
    logic                  tail_reg;
    logic                  push_eff;
    logic                  pop_eff;

    always_comb begin
        push_eff   = push && !flush;
        pop_eff    = pop && !flush && (state_reg != EMPTY);
        state_next = state_reg;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY: if (push_eff) state_next = ONE;
                ONE: begin
                    if (push_eff && !pop_eff)      state_next = TWO;
                    else if (!push_eff && pop_eff) state_next = EMPTY;
                end
                TWO:     if (pop_eff && !push_eff) state_next = ONE;
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= EMPTY;
            head_reg   <= 1'b0;
            tail_reg   <= 1'b0;
            mem_reg[0] <= '0;
            mem_reg[1] <= '0;
        end else begin
            state_reg <= state_next;
            if (flush) begin
                head_reg <= 1'b0;
                tail_reg <= 1'b0;
            end else begin
                if (push_eff) begin
                    mem_reg[tail_reg] <= push_data;
                    tail_reg          <= ~tail_reg;
                end
                if (pop_eff) begin
                    head_reg <= ~head_reg;
                end
            end
        end
    end

    assign state     = state_reg;
    assign valid     = (state_reg != EMPTY);
    assign head_data = mem_reg[head_reg];

    // The read-request logic must never let a word land on a full buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_eff && !pop_eff && state_reg == TWO));

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the sync_fifo read port into a valid/ready stream at one word per cycle.
// rstn is an asynchronous, active-HIGH reset despite its name.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int data_width = DATA_WIDTH_DEF,
    parameter int cnt_width  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  empty,
    input  logic [data_width-1:0] data_out,
    output logic                  rd_ena,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [data_width-1:0] m_data,
    output logic [cnt_width-1:0]  word_cnt
);

    occ_t                 occ;
    logic                 inflight_reg;
    logic                 pop_req;
    logic [2:0]           fill;
    logic [cnt_width-1:0] word_cnt_reg;

    assign pop_req = m_valid && m_ready;

    // Buffer slots committed by the end of this cycle; a read is only
    // issued when its word is guaranteed a free slot on arrival.
    always_comb begin
        fill   = occ_level(occ) + {2'b00, inflight_reg} - {2'b00, pop_req};
        rd_ena = !rstn && !flush && !empty && (fill < 3'd2);
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            inflight_reg <= 1'b0;
            word_cnt_reg <= '0;
        end else begin
            inflight_reg <= rd_ena;
            if (pop_req && !flush) begin
                word_cnt_reg <= word_cnt_reg + 1'b1;
            end
        end
    end

    skid_buf2 #(
        .data_width(data_width)
    ) u_skid (
        .clk      (clk),
        .rst      (rstn),
        .flush    (flush),
        .push     (inflight_reg),
        .push_data(data_out),
        .pop      (pop_req),
        .state    (occ),
        .valid    (m_valid),
        .head_data(m_data)
    );

    assign word_cnt = word_cnt_reg;

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 The block SHALL take parameter data_width, default 8, meaning the FIFO word and stream data width in bits.
REQ-002 The block SHALL take parameter cnt_width, default 16, meaning the width of the delivered-word counter.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1: reset, asynchronous and active-high.
REQ-005 The block SHALL have port flush, input, 1: synchronous buffer clear.
REQ-006 The block SHALL have port empty, input, 1, the sync_fifo empty flag.
REQ-007 The block SHALL have port data_out, input, data_width, the sync_fifo read data, valid one cycle after rd_ena.
REQ-008 The block SHALL have port rd_ena, output, 1, the sync_fifo read strobe.
REQ-009 The block SHALL have port m_valid, output, 1: stream word valid.
REQ-010 The block SHALL have port m_ready, input, 1: stream consumer ready.
REQ-011 The block SHALL have port m_data, output, data_width: stream word.
REQ-012 The block SHALL have port word_cnt, output, cnt_width: count of words accepted by the consumer.

Function
REQ-013 The block SHALL drain the sync_fifo read side and present words on a valid/ready stream with no loss, duplication or reordering.
REQ-014 The block SHALL hold a 2-entry output buffer whose occupancy FSM has states EMPTY, ONE and TWO.
REQ-015 The block SHALL assert rd_ena combinationally when all of the following hold: empty=0, flush=0, and occupancy + in-flight read (0/1) + (pop this cycle ? -1 : 0) < 2.
REQ-016 The block SHALL register an in-flight flag equal to rd_ena, and write data_out into the buffer tail on the cycle the flag is 1.
REQ-017 A pop SHALL occur when m_valid=1 and m_ready=1; m_valid SHALL equal (occupancy != EMPTY); m_data SHALL equal the buffer head.
REQ-018 The FSM SHALL transition as follows:
- push only: EMPTY->ONE, ONE->TWO.
- pop only: TWO->ONE, ONE->EMPTY.
- push and pop: state unchanged; head advances.
REQ-019 A push in state TWO without a pop SHALL be impossible by REQ-015; an assertion SHALL flag it.
REQ-020 m_valid and m_data SHALL be stable while m_valid=1 and m_ready=0.
REQ-021 Sustained throughput SHALL be 1 word/cycle when empty=0 and m_ready=1.
REQ-022 First-word latency SHALL be: empty falls at cycle N -> rd_ena at N -> m_valid at N+2.
REQ-023 word_cnt SHALL increment by 1 per pop and wrap modulo 2^cnt_width.
REQ-024 On flush=1, on the next edge the FSM SHALL go to EMPTY, the in-flight word SHALL be discarded, and rd_ena SHALL be 0 that cycle; word_cnt SHALL be unchanged.
REQ-025 Flush takes priority over a simultaneous push or pop; a pop in the flush cycle SHALL NOT count.

Reset
REQ-026 While rstn=1, all of the following SHALL hold asynchronously: FSM=EMPTY, in-flight=0, head/tail pointers=0, word_cnt=0, m_valid=0, m_data=0, rd_ena=0.
REQ-027 A reset asserted mid-transfer SHALL discard buffered and in-flight words; the first rising edge after rstn falls SHALL be a normal cycle.

Structure
REQ-028 Shared package fifo_pkg SHALL hold the data_width/cnt_width defaults and the occupancy enum typedef (EMPTY, ONE, TWO); sync_fifo and this block both import it.
REQ-029 The 2-entry storage, pointers and FSM SHALL be a sub-module named skid_buf2; fifo_rd_stream SHALL hold the rd_ena logic, the in-flight flag and word_cnt.

Verification
REQ-030 Fill sync_fifo with 0x11,0x22,0x33, m_ready=1 -> m_data 0x11,0x22,0x33 on consecutive cycles; first m_valid 2 cycles after empty falls; word_cnt=3.
REQ-031 m_ready=0, FIFO holding 5 words -> exactly 2 rd_ena pulses, then rd_ena=0, state TWO, m_data stable; release m_ready -> all 5 words in order.
REQ-032 m_ready toggled 1010..., 20 words 0x00-0x13 -> no loss or duplicate; word_cnt=20.
REQ-033 Flush asserted with state TWO and a read in flight -> next cycle m_valid=0, rd_ena=0; following words resume in order; word_cnt unchanged.
REQ-034 rstn pulse mid-stream -> all outputs 0 immediately; after release, streaming restarts from the FIFO's post-reset contents.
REQ-035 Preload word_cnt to 0xFFFE (cnt_width=16), 3 pops -> word_cnt reads 0xFFFF, 0x0000, 0x0001.
